// File: rtl/demux_stream_1_n_pkg.sv
// Shared constants for the registered 1:N stream demux: channel state encodings
// and stats counter width/saturation. Stats are built only under DEMUX_STREAM_STATS_EN.
package demux_stream_1_n_pkg;

  localparam logic [0:0] CH_EMPTY = 1'b0;
  localparam logic [0:0] CH_FULL  = 1'b1;

  localparam int                 STATS_W   = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == STATS_MAX) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/demux_stream_1_n_chan.sv
// One output channel: a one-entry register with a state bit and idle masking.
// DEMUX_STREAM_STATS_EN adds a saturating output-transfer counter.
module demux_stream_chan
  import demux_stream_1_n_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ZERO_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DEMUX_STREAM_STATS_EN
  ,
  input  logic               clr_stats,
  output logic [STATS_W-1:0] xfer_cnt
`endif
);

  logic [0:0]       st;
  logic [WIDTH-1:0] data_q;

  // A load wins over a drain so a FULL channel reloads in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= CH_EMPTY;
      data_q <= '0;
    end else if (load) begin
      st     <= CH_FULL;
      data_q <= din;
    end else if (out_ready) begin
      st     <= CH_EMPTY;
    end
  end

  assign out_valid = (st == CH_FULL);
  assign out_data  = (ZERO_IDLE != 0 && st == CH_EMPTY) ? '0 : data_q;

`ifdef DEMUX_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      xfer_cnt <= '0;
    else if (clr_stats)              xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= sat_inc(xfer_cnt);
  end
`endif

endmodule

// File: rtl/demux_stream_1_n.sv
// Registered 1:N stream demux: select decode, in_ready mux and sel_err pulse.
// DEMUX_STREAM_STATS_EN adds err_cnt, per-channel xfer_cnt and clr_stats.
module demux_stream_1_n
  import demux_stream_1_n_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int SEL_W     = 2,
  parameter int ZERO_IDLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               sel_err
`ifdef DEMUX_STREAM_STATS_EN
  ,
  input  logic                 clr_stats,
  output logic [STATS_W-1:0]   err_cnt,
  output logic [N*STATS_W-1:0] xfer_cnt
`endif
);

  if ((2 ** SEL_W) < N) begin : g_bad_sel_w
    $error("demux_stream_1_n: SEL_W too narrow for N");
  end

  logic                    oor;
  logic                    xfer_in;
  logic [(2**SEL_W)-1:0]   ch_rdy;
  logic [N-1:0]            load;

  assign oor = (32'(in_sel) >= 32'(N));

  // Unused select codes read as ready so out-of-range words are always drained.
  always_comb begin
    ch_rdy = '1;
    for (int k = 0; k < N; k++) ch_rdy[k] = ~out_valid[k] | out_ready[k];
  end

  assign in_ready = oor | ch_rdy[in_sel];
  assign xfer_in  = in_valid & in_ready;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign load[k] = xfer_in & (32'(in_sel) == k);

    demux_stream_chan #(
      .WIDTH     (WIDTH),
      .ZERO_IDLE (ZERO_IDLE)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .din       (in_data),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_STREAM_STATS_EN
      ,
      .clr_stats (clr_stats),
      .xfer_cnt  (xfer_cnt[k*STATS_W +: STATS_W])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= xfer_in & oor;
  end

`ifdef DEMUX_STREAM_STATS_EN
  // Counted at acceptance so err_cnt moves on the same edge sel_err rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_cnt <= '0;
    else if (clr_stats)      err_cnt <= '0;
    else if (xfer_in && oor) err_cnt <= sat_inc(err_cnt);
  end
`endif

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Directed bench: u0 N=4 zero-idle, u1 N=3 for out-of-range selects, u2 N=4 hold-last-data.
module tb_demux_stream_1_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v0 = 0, rdy0, se0;
  logic [1:0]  s0 = 0;
  logic [7:0]  d0 = 0;
  logic [3:0]  or0 = 0, ov0;
  logic [31:0] od0;

  logic        v1 = 0, rdy1, se1;
  logic [1:0]  s1 = 0;
  logic [7:0]  d1 = 0;
  logic [2:0]  or1 = 0, ov1;
  logic [23:0] od1;

  logic        v2 = 0, rdy2, se2;
  logic [1:0]  s2 = 0;
  logic [7:0]  d2 = 0;
  logic [3:0]  or2 = 0, ov2;
  logic [31:0] od2;

`ifdef DEMUX_STREAM_STATS_EN
  logic        clr = 0;
  logic [15:0] ec0, ec1, ec2;
  logic [63:0] xc0, xc2;
  logic [47:0] xc1;
`endif

  demux_stream_1_n #(.WIDTH(8), .N(4), .SEL_W(2), .ZERO_IDLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_sel(s0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .sel_err(se0)
`ifdef DEMUX_STREAM_STATS_EN
    , .clr_stats(clr), .err_cnt(ec0), .xfer_cnt(xc0)
`endif
  );

  demux_stream_1_n #(.WIDTH(8), .N(3), .SEL_W(2), .ZERO_IDLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_sel(s1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .sel_err(se1)
`ifdef DEMUX_STREAM_STATS_EN
    , .clr_stats(clr), .err_cnt(ec1), .xfer_cnt(xc1)
`endif
  );

  demux_stream_1_n #(.WIDTH(8), .N(4), .SEL_W(2), .ZERO_IDLE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_sel(s2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .sel_err(se2)
`ifdef DEMUX_STREAM_STATS_EN
    , .clr_stats(clr), .err_cnt(ec2), .xfer_cnt(xc2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ov0", ov0, 4'b0000);
    chk("rst_od0", od0, 32'h0);
    chk("rst_se0", se0, 1'b0);
    chk("rst_se1", se1, 1'b0);
    cyc();
    rst_n = 1'b1;
    #1 chk("rst_rdy0", rdy0, 1'b1);

    // reset mid-stream: ch2 FULL with A5, reset between edges
    cyc();
    v0 = 1; s0 = 2; d0 = 8'hA5;
    cyc();
    v0 = 0;
    chk("full_ov0", ov0, 4'b0100);
    chk("full_od0", od0, 32'h00A5_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ov0", ov0, 4'b0000);
    chk("async_od0", od0, 32'h0);
    cyc();
    rst_n = 1'b1;
    #1 chk("post_rst_rdy0", rdy0, 1'b1);

    // basic routing
    cyc();
    or0 = 4'hF; v0 = 1;
    s0 = 0; d0 = 8'h11; cyc();
    chk("route0_ov", ov0, 4'b0001); chk("route0_od", od0, 32'h0000_0011);
    s0 = 1; d0 = 8'h22; cyc();
    chk("route1_ov", ov0, 4'b0010); chk("route1_od", od0, 32'h0000_2200);
    s0 = 2; d0 = 8'h33; cyc();
    chk("route2_ov", ov0, 4'b0100); chk("route2_od", od0, 32'h0033_0000);
    s0 = 3; d0 = 8'h44; cyc();
    chk("route3_ov", ov0, 4'b1000); chk("route3_od", od0, 32'h4400_0000);
    v0 = 0; cyc();
    chk("route_idle_ov", ov0, 4'b0000);

    // stall isolation on ch1
    or0 = 4'b1101; v0 = 1; s0 = 1; d0 = 8'h10;
    #1 chk("stall_rdy_a", rdy0, 1'b1);
    cyc();
    chk("stall_ov_a", ov0, 4'b0010); chk("stall_od_a", od0, 32'h0000_1000);
    d0 = 8'h20;
    #1 chk("stall_rdy_b", rdy0, 1'b0);
    cyc();
    chk("stall_hold_ov", ov0, 4'b0010); chk("stall_hold_od", od0, 32'h0000_1000);
    chk("stall_rdy_c", rdy0, 1'b0);
    or0 = 4'hF;
    #1 chk("stall_rdy_d", rdy0, 1'b1);
    cyc();
    chk("stall_reload_od", od0, 32'h0000_2000);
    or0 = 4'b1101; s0 = 3; d0 = 8'h30;
    #1 chk("stall_rdy_ch3", rdy0, 1'b1);
    cyc();
    chk("iso_ov", ov0, 4'b1010); chk("iso_od", od0, 32'h3000_2000);
    v0 = 0; cyc();
    chk("iso_drain_ov", ov0, 4'b0010); chk("iso_drain_od", od0, 32'h0000_2000);
    or0 = 4'hF; cyc();
    chk("iso_empty_ov", ov0, 4'b0000);

    // back-to-back on ch0
    v0 = 1; s0 = 0;
    for (int i = 1; i <= 5; i++) begin
      d0 = 8'(i);
      #1 chk("b2b_rdy", rdy0, 1'b1);
      cyc();
      chk("b2b_ov", ov0, 4'b0001);
      chk("b2b_od", od0, 32'(i));
    end
    v0 = 0; cyc();
    chk("b2b_end_ov", ov0, 4'b0000);
    chk("se0_never", se0, 1'b0);

    // out-of-range select on N=3, ch0 held FULL across it
    or1 = 3'b110; v1 = 1; s1 = 0; d1 = 8'h77; cyc();
    chk("oor_pre_ov", ov1, 3'b001);
    s1 = 3; d1 = 8'hEE;
    #1 chk("oor_rdy", rdy1, 1'b1);
    cyc();
    v1 = 0;
    chk("oor_sel_err", se1, 1'b1);
    chk("oor_ov", ov1, 3'b001);
    chk("oor_od", od1, 24'h00_0077);
    cyc();
    chk("oor_sel_err_off", se1, 1'b0);

    // hold-last-data channel
    or2 = 4'hF; v2 = 1; s2 = 2; d2 = 8'h5A; cyc();
    v2 = 0;
    chk("zi0_ov", ov2, 4'b0100); chk("zi0_od", od2, 32'h005A_0000);
    cyc();
    chk("zi0_drained_ov", ov2, 4'b0000); chk("zi0_held_od", od2, 32'h005A_0000);

`ifdef DEMUX_STREAM_STATS_EN
    chk("err_cnt1", ec1, 16'd1);
    chk("err_cnt0", ec0, 16'd0);
    chk("xfer_cnt0", xc0, 64'h0002_0001_0003_0006);
    chk("xfer_cnt2", xc2, 64'h0000_0001_0000_0000);
    clr = 1; cyc(); clr = 0;
    chk("clr_err_cnt1", ec1, 16'd0);
    chk("clr_xfer_cnt0", xc0, 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
